mc_sequencer: RTL
=================

# mc_sequencer

Multi-cycle phase sequencer for the MIPS multi-cycle CPU. It sits directly downstream of the combinational opcode decoder (`CU`) and consumes its level-type control flags. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and emits the per-cycle enables that drive the PC, IR, memory and register file. It also provides memory-wait handshaking, a memory timeout fault, and a retired-instruction counter.

## Interface

Parameters:

- `MEM_TIMEOUT`, default 8: maximum number of consecutive wait cycles for `mem_ready` in FETCH or MEM before a fault is raised. Legal range is 1..255.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:

- `clock`  in  1  Single clock. All state changes on the rising edge.
- `resetn`  in  1  Reset, synchronous, active-low.
- `cu_regwrite, cu_memrd, cu_memwr, cu_branch, cu_bne, cu_jnot, cu_sijal`  in  1 each  Decoder flags derived from the IR. `cu_jnot`=0 means j/jal.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  Memory acknowledge for the current `mem_rd`/`mem_wr` cycle.
- `ir_write`  out  1  Load the IR.
- `pc_write`  out  1  Load the PC.
- `pc_src`  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- `iord`  out  1  Memory address source: 0 = PC, 1 = ALUOut.
- `mem_rd`  out  1  Memory read request.
- `mem_wr`  out  1  Memory write request.
- `reg_write`  out  1  Register-file write enable.
- `state`  out  3  Current state encoding.
- `instr_done`  out  1  One-cycle pulse when an instruction retires.
- `instr_count`  out  `CNT_W`  Number of retired instructions.
- `fault`  out  1  Sticky memory-timeout flag.

## Operation

State encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, FAULT = 7.

Outputs are combinational from state, the decoder flags, `zero` and `mem_ready`. Any output not named for a state is 0.

- **FETCH**
  - Outputs: `mem_rd`=1, `iord`=0.
  - If `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=00, then go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE**
  - Decoder flags are valid from this state onward.
  - If `cu_jnot`=0: `pc_write`=1, `pc_src`=10, `reg_write`=`cu_sijal` (jal writes $31), then retire and go to FETCH.
  - Otherwise go to EXEC.
- **EXEC**, checked in priority order:
  - If `cu_branch`: `pc_write`=`zero`, `pc_src`=01, retire.
  - Else if `cu_bne`: `pc_write`=~`zero`, `pc_src`=01, retire.
  - Else if `cu_memrd` or `cu_memwr`: go to MEM.
  - Else if `cu_regwrite`: go to WB.
  - Else: retire (unsupported or no-op opcode).
- **MEM**
  - Outputs: `iord`=1, `mem_rd`=`cu_memrd`, `mem_wr`=`cu_memwr & ~cu_memrd`.
  - If `mem_rd` and `mem_wr` are both requested, the read takes priority.
  - On `mem_ready`: a write retires; a read goes to WB.
- **WB**
  - `reg_write`=1, then retire.
- **FAULT**
  - All enables are 0 and `fault`=1.
  - The block stays in FAULT until reset.

Retire means:

- `instr_done`=1 for that cycle.
- `instr_count` increments on the same edge, wrapping from all-ones to 0.
- The next state is FETCH.

Wait timer:

- The timer counts consecutive cycles in FETCH or MEM with `mem_ready`=0.
- It clears on `mem_ready`=1 and on any state change.
- When it reaches `MEM_TIMEOUT` with `mem_ready` still 0, the next state is FAULT.
- A `mem_ready` arriving in that same cycle wins: the normal transition is taken and no fault is raised.

## Timing

- While `resetn`=0 at a clock edge:
  - `state` becomes FETCH and the timer becomes 0.
  - `instr_count` becomes 0 and `fault` becomes 0.
  - All enables are forced to 0 while `resetn` is low.
- The first `mem_rd`=1 appears in the first cycle after `resetn` returns high.
- Reset taken mid-instruction (any state, including FAULT) aborts the instruction without retiring it.
- Latency per instruction, with zero wait states:
  - j/jal: 2 cycles.
  - beq/bne/no-op: 3 cycles.
  - R-type/addi/slt: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- Each `mem_ready`=0 cycle in FETCH or MEM adds one cycle.
- `mem_ready` is sampled only in FETCH and MEM; it is ignored in all other states.
- `ir_write` and `pc_write` in FETCH are asserted only in the acknowledge cycle, which is a single cycle.

## Structure

- Shared package `mc_seq_pkg` holds:
  - the state enum encodings;
  - the `pc_src` encodings (`PC_PLUS4`, `PC_BRANCH`, `PC_JUMP`);
  - the opcode constants used by the bench (R = 0x00, j = 0x02, jal = 0x03, beq = 0x04, bne = 0x05, lw = 0x23, sw = 0x2B, slti = 0x0A).
- One sub-module, `mem_wait_timer`:
  - 8-bit saturating counter;
  - inputs: `clock`, `resetn`, clear, count;
  - output: expired.

## Test plan

- **lw (0x23) with `mem_ready` tied high:** states 0→1→2→3→4→0. `mem_rd`=1 with `iord`=1 in MEM. `reg_write`=1 in cycle 5. `instr_count` goes 0→1.
- **beq (0x04):**
  - With `zero`=1: `pc_write`=1 and `pc_src`=01 in EXEC (cycle 3).
  - Repeated with `zero`=0: `pc_write`=0. `instr_done` pulses in both cases.
- **jal (0x03):** DECODE asserts `pc_write`=1, `pc_src`=10 and `reg_write`=1. Total of 2 cycles, with no EXEC state.
- **sw (0x2B) with `mem_ready` low for 3 MEM cycles:** `mem_wr` is held for 4 cycles. Retires with `reg_write` never asserted. 7 cycles total.
- **Timeout, `MEM_TIMEOUT`=8, `mem_ready` stuck at 0 in FETCH:** `state`=7 and `fault`=1 after 8 wait cycles, and all enables are 0. Asserting `resetn`=0 returns to FETCH with `fault`=0.
- **Reset and counter wrap:**
  - Reset asserted in MEM: next cycle is FETCH, `instr_count`=0, no `instr_done`.
  - With `CNT_W`=4, retiring 16 instructions wraps the count 15→0.

Source files
------------

// File: rtl/mc_seq_pkg.sv
// Shared types and constants for the multi-cycle phase sequencer.
// Holds the state encodings, PC source selects and the opcode values the bench decodes.
package mc_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd7
  } state_e;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // FETCH and MEM are the only states that wait on memory.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/mc_sequencer_mem_wait_timer.sv
// Saturating 8-bit wait-cycle counter for memory handshakes.
// expired flags the cycle in which the LIMIT-th consecutive wait is being counted.
module mem_wait_timer #(
  parameter int unsigned LIMIT = 8
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [7:0] LIMIT_M1 = 8'(LIMIT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (count && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // cnt_q holds the waits already seen, so the current wait is number cnt_q+1.
  assign expired = count && (cnt_q >= LIMIT_M1);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS multi-cycle CPU.
// Drives PC/IR/memory/register-file enables, handles memory waits and counts retirements.
module mc_sequencer
  import mc_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             cu_regwrite,
  input  logic             cu_memrd,
  input  logic             cu_memwr,
  input  logic             cu_branch,
  input  logic             cu_bne,
  input  logic             cu_jnot,
  input  logic             cu_sijal,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             reg_write,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic             fault
);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             retire;
  logic             timer_count;
  logic             timer_clear;
  logic             timer_expired;

  assign timer_count = is_wait_state(state_q) && !mem_ready;
  assign timer_clear = !timer_count || (state_d != state_q);

  mem_wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_timer (
    .clock  (clock),
    .resetn (resetn),
    .clear  (timer_clear),
    .count  (timer_count),
    .expired(timer_expired)
  );

  always_comb begin
    state_d   = state_q;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    iord      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    reg_write = 1'b0;
    retire    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (timer_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        if (!cu_jnot) begin
          pc_write  = 1'b1;
          pc_src    = PC_JUMP;
          reg_write = cu_sijal;
          retire    = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cu_branch) begin
          pc_write = zero;
          pc_src   = PC_BRANCH;
          retire   = 1'b1;
        end else if (cu_bne) begin
          pc_write = ~zero;
          pc_src   = PC_BRANCH;
          retire   = 1'b1;
        end else if (cu_memrd || cu_memwr) begin
          state_d = ST_MEM;
        end else if (cu_regwrite) begin
          state_d = ST_WB;
        end else begin
          retire = 1'b1;
        end
      end
      ST_MEM: begin
        iord   = 1'b1;
        mem_rd = cu_memrd;
        mem_wr = cu_memwr & ~cu_memrd;
        if (mem_ready) begin
          if (cu_memrd) begin
            state_d = ST_WB;
          end else begin
            retire = 1'b1;
          end
        end else if (timer_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase

    if (retire) begin
      state_d = ST_FETCH;
    end

    // Reset is synchronous, so the enables are masked combinationally while it is held.
    if (!resetn) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_PLUS4;
      iord      = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
    end
  end

  assign count_d = count_q + CNT_W'(retire);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign state       = state_q;
  assign instr_done  = retire;
  assign instr_count = count_q;
  assign fault       = (state_q == ST_FAULT);

endmodule
